sdr_wr_sched: RTL and testbench

- Write-command scheduler that sits directly upstream of the SDRAM write stage (sdr_wr).
- Accepts user write commands through a valid/ready handshake and buffers them in a small FIFO.
- Splits each linear address into bank/row/col and issues one sdr_wr_req pulse per command, then waits for wr_exit before issuing the next.
- Owns the periodic auto-refresh timer and arbitrates refresh against writes, with refresh taking priority at command boundaries.

---
 rtl/sdr_wr_sched.sv | 152 +++++++++++++++
 tb/tb_sdr_wr_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_wr_sched.sv
// Write-command scheduler in front of the SDRAM write stage: buffers user writes,
// issues one request per command and interleaves periodic auto-refresh.
module sdr_wr_sched #(
  parameter int DEPTH        = 4,
  parameter int AW           = 24,
  parameter int REF_INTERVAL = 1300
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_done,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [15:0]              wr_data,
  output logic                     sdr_wr_req,
  output logic [1:0]               sdr_bank_addr,
  output logic [12:0]              sdr_row_addr,
  output logic [8:0]               sdr_col_addr,
  output logic [15:0]              sdr_wr_data,
  input  logic                     wr_exit,
  output logic                     ref_req,
  input  logic                     ref_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ref_overrun
);

  localparam int DATA_W = 16;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int TW     = $clog2(REF_INTERVAL + 1);
  localparam int EW     = AW + DATA_W;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_REQ,
    S_WAIT_WR,
    S_REF
  } state_t;

  state_t          state_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            ref_pend_q, ref_overrun_q;
  logic [1:0]      bank_q;
  logic [12:0]     row_q;
  logic [8:0]      col_q;
  logic [DATA_W-1:0] data_q;

  logic          full, empty, push, pop, wrap;
  logic [EW-1:0] head;
  logic [AW-1:0] head_addr;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_ready  = (state_q != S_WAIT_INIT) && !full;
  assign push      = wr_valid && wr_ready;
  // The head stays buffered while its write is in flight; it leaves only on wr_exit.
  assign pop       = (state_q == S_WAIT_WR) && wr_exit;
  assign head      = mem_q[rd_ptr_q];
  assign head_addr = head[EW-1 -: AW];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign wrap = (state_q != S_WAIT_INIT) && (tmr_q == TW'(REF_INTERVAL - 1));

  always_comb begin
    tmr_d = tmr_q + TW'(1);
    if (state_q == S_WAIT_INIT || wrap) tmr_d = '0;
  end

  // A wrap coinciding with ref_done keeps the request pending for another round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q         <= '0;
      ref_pend_q    <= 1'b0;
      ref_overrun_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      if (wrap) begin
        ref_pend_q <= 1'b1;
        if (ref_pend_q) ref_overrun_q <= 1'b1;
      end else if (state_q == S_REF && ref_done) begin
        ref_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT_INIT;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_WAIT_INIT: if (init_done) state_q <= S_IDLE;
        S_IDLE: begin
          if (ref_pend_q) begin
            state_q <= S_REF;
          end else if (!empty) begin
            state_q <= S_REQ;
            bank_q  <= head_addr[AW-1 -: 2];
            row_q   <= head_addr[AW-3 -: 13];
            col_q   <= head_addr[8:0];
            data_q  <= head[DATA_W-1:0];
          end
        end
        S_REQ:     state_q <= S_WAIT_WR;
        S_WAIT_WR: if (wr_exit)  state_q <= S_IDLE;
        S_REF:     if (ref_done) state_q <= S_IDLE;
        default:   state_q <= S_WAIT_INIT;
      endcase
    end
  end

  assign sdr_wr_req    = (state_q == S_REQ);
  assign ref_req       = (state_q == S_REF);
  assign sdr_bank_addr = bank_q;
  assign sdr_row_addr  = row_q;
  assign sdr_col_addr  = col_q;
  assign sdr_wr_data   = data_q;
  assign fifo_count    = count_q;
  assign ref_overrun   = ref_overrun_q;

endmodule

// File: tb/tb_sdr_wr_sched.sv
// Directed bench for sdr_wr_sched: init gating, single write, back-pressure,
// refresh priority, refresh overrun and reset mid-operation.
module tb_sdr_wr_sched;
  localparam int RI = 200;

  logic        clk = 1'b0;
  logic        rst, init_done, wr_valid, wr_exit, ref_done;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready, sdr_wr_req, ref_req, ref_overrun;
  logic [1:0]  sdr_bank_addr;
  logic [12:0] sdr_row_addr;
  logic [8:0]  sdr_col_addr;
  logic [15:0] sdr_wr_data;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  logic [23:0] ca [5];
  logic [15:0] cd [5];

  sdr_wr_sched #(.DEPTH(4), .AW(24), .REF_INTERVAL(RI)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .sdr_wr_req(sdr_wr_req), .sdr_bank_addr(sdr_bank_addr), .sdr_row_addr(sdr_row_addr),
    .sdr_col_addr(sdr_col_addr), .sdr_wr_data(sdr_wr_data), .wr_exit(wr_exit),
    .ref_req(ref_req), .ref_done(ref_done), .fifo_count(fifo_count),
    .ref_overrun(ref_overrun)
  );

  always #3 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1; wr_valid = 1'b0; wr_exit = 1'b0; ref_done = 1'b0; init_done = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push(input logic [23:0] a, input logic [15:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input logic [23:0] a, input logic [15:0] d);
    chk({tag, ".req"}, 32'(sdr_wr_req), 32'd1);
    chk({tag, ".addr"}, 32'({sdr_bank_addr, sdr_row_addr, sdr_col_addr}), 32'(a));
    chk({tag, ".data"}, 32'(sdr_wr_data), 32'(d));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req"},   32'(sdr_wr_req), 32'd0);
    chk({tag, ".ref"},   32'(ref_req), 32'd0);
    chk({tag, ".rdy"},   32'(wr_ready), 32'd0);
    chk({tag, ".cnt"},   32'(fifo_count), 32'd0);
    chk({tag, ".ovr"},   32'(ref_overrun), 32'd0);
    chk({tag, ".bank"},  32'(sdr_bank_addr), 32'd0);
    chk({tag, ".row"},   32'(sdr_row_addr), 32'd0);
    chk({tag, ".col"},   32'(sdr_col_addr), 32'd0);
    chk({tag, ".data"},  32'(sdr_wr_data), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ca[0] = 24'h000001; cd[0] = 16'h1111;
    ca[1] = 24'h400200; cd[1] = 16'h2222;
    ca[2] = 24'h8123AB; cd[2] = 16'h3333;
    ca[3] = 24'hC00000; cd[3] = 16'h4444;
    ca[4] = 24'hFFFFFF; cd[4] = 16'h5A5A;

    // Init gating
    rst = 1'b1; init_done = 1'b0; wr_valid = 1'b1; wr_exit = 1'b0; ref_done = 1'b0;
    wr_addr = 24'h123456; wr_data = 16'hBEEF;
    #1;
    chk_zero("rst0");
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("init.rdy", 32'(wr_ready), 32'd0);
      chk("init.req", 32'(sdr_wr_req), 32'd0);
      chk("init.ref", 32'(ref_req), 32'd0);
    end
    chk("init.cnt", 32'(fifo_count), 32'd0);
    init_done = 1'b1; wr_valid = 1'b0;
    tick();
    chk("init.rdy_up", 32'(wr_ready), 32'd1);

    // Single write: 0x9ABCDE -> bank 2, row 0x0D5E, col 0x0DE
    push(24'h9ABCDE, 16'h5555);
    chk("single.cnt1", 32'(fifo_count), 32'd1);
    chk("single.noreq", 32'(sdr_wr_req), 32'd0);
    tick();
    chk("single.req", 32'(sdr_wr_req), 32'd1);
    chk("single.bank", 32'(sdr_bank_addr), 32'd2);
    chk("single.row", 32'(sdr_row_addr), 32'h0D5E);
    chk("single.col", 32'(sdr_col_addr), 32'h0DE);
    chk("single.data", 32'(sdr_wr_data), 32'h5555);
    tick();
    chk("single.pulse", 32'(sdr_wr_req), 32'd0);
    chk("single.hold", 32'(sdr_col_addr), 32'h0DE);
    repeat (11) tick();
    chk("single.wait_cnt", 32'(fifo_count), 32'd1);
    wr_exit = 1'b1;
    tick();
    wr_exit = 1'b0;
    chk("single.cnt0", 32'(fifo_count), 32'd0);
    chk("single.idle_rdy", 32'(wr_ready), 32'd1);
    tick();
    chk("single.idle_req", 32'(sdr_wr_req), 32'd0);
    chk("single.idle_ref", 32'(ref_req), 32'd0);

    // FIFO full / back-pressure
    restart();
    wr_valid = 1'b1; wr_addr = ca[0]; wr_data = cd[0];
    tick();
    chk("full.cnt1", 32'(fifo_count), 32'd1);
    wr_addr = ca[1]; wr_data = cd[1];
    tick();
    chk("full.cnt2", 32'(fifo_count), 32'd2);
    chk_cmd("full.c0", ca[0], cd[0]);
    wr_addr = ca[2]; wr_data = cd[2];
    tick();
    chk("full.cnt3", 32'(fifo_count), 32'd3);
    wr_addr = ca[3]; wr_data = cd[3];
    tick();
    chk("full.cnt4", 32'(fifo_count), 32'd4);
    chk("full.rdy0", 32'(wr_ready), 32'd0);
    wr_addr = ca[4]; wr_data = cd[4];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full.hold_cnt", 32'(fifo_count), 32'd4);
      chk("full.hold_rdy", 32'(wr_ready), 32'd0);
      chk("full.hold_req", 32'(sdr_wr_req), 32'd0);
    end
    wr_exit = 1'b1;
    tick();
    wr_exit = 1'b0;
    chk("full.pop_cnt", 32'(fifo_count), 32'd3);
    chk("full.pop_rdy", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("full.refill", 32'(fifo_count), 32'd4);
    chk_cmd("full.c1", ca[1], cd[1]);
    for (int k = 2; k < 5; k++) begin
      tick();
      wr_exit = 1'b1;
      tick();
      wr_exit = 1'b0;
      chk("full.drain_cnt", 32'(fifo_count), 32'(5 - k));
      tick();
      chk_cmd("full.ck", ca[k], cd[k]);
    end
    tick();
    wr_exit = 1'b1;
    tick();
    wr_exit = 1'b0;
    chk("full.empty", 32'(fifo_count), 32'd0);
    tick();
    chk("full.no_more", 32'(sdr_wr_req), 32'd0);

    // Refresh priority: wrap at edge RI while the first command is in flight
    restart();
    repeat (RI - 6) tick();
    push(ca[0], cd[0]);
    push(ca[1], cd[1]);
    push(ca[2], cd[2]);
    chk("refp.cnt3", 32'(fifo_count), 32'd3);
    repeat (5) tick();
    chk("refp.no_interrupt", 32'(ref_req), 32'd0);
    wr_exit = 1'b1;
    tick();
    wr_exit = 1'b0;
    chk("refp.exit_cnt", 32'(fifo_count), 32'd2);
    chk("refp.exit_ref", 32'(ref_req), 32'd0);
    tick();
    chk("refp.ref_first", 32'(ref_req), 32'd1);
    chk("refp.no_req", 32'(sdr_wr_req), 32'd0);
    repeat (3) tick();
    chk("refp.ref_held", 32'(ref_req), 32'd1);
    chk("refp.cnt_held", 32'(fifo_count), 32'd2);
    ref_done = 1'b1;
    tick();
    ref_done = 1'b0;
    chk("refp.ref_drop", 32'(ref_req), 32'd0);
    chk("refp.req_wait", 32'(sdr_wr_req), 32'd0);
    tick();
    chk_cmd("refp.c1", ca[1], cd[1]);
    chk("refp.ovr", 32'(ref_overrun), 32'd0);

    // Refresh overrun: ref_done withheld across a second wrap
    restart();
    repeat (RI) tick();
    chk("ovr.pend_idle", 32'(ref_req), 32'd0);
    tick();
    chk("ovr.ref_req", 32'(ref_req), 32'd1);
    repeat (RI - 2) tick();
    chk("ovr.before", 32'(ref_overrun), 32'd0);
    tick();
    chk("ovr.set", 32'(ref_overrun), 32'd1);
    ref_done = 1'b1;
    tick();
    ref_done = 1'b0;
    chk("ovr.after_done", 32'(ref_overrun), 32'd1);
    chk("ovr.ref_off", 32'(ref_req), 32'd0);
    repeat (5) tick();
    chk("ovr.sticky", 32'(ref_overrun), 32'd1);
    chk("ovr.no_reref", 32'(ref_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("ovr.rst_clear", 32'(ref_overrun), 32'd0);

    // Reset mid-operation with three commands queued
    restart();
    push(ca[2], cd[2]);
    push(ca[3], cd[3]);
    push(ca[4], cd[4]);
    tick();
    chk("rmid.cnt3", 32'(fifo_count), 32'd3);
    chk("rmid.col", 32'(sdr_col_addr), 32'(ca[2][8:0]));
    rst = 1'b1;
    #1;
    chk_zero("rmid");
    tick();
    init_done = 1'b0;
    rst = 1'b0;
    wr_exit = 1'b1; ref_done = 1'b1;
    tick();
    wr_exit = 1'b0; ref_done = 1'b0;
    chk("rmid.stale_cnt", 32'(fifo_count), 32'd0);
    chk("rmid.stale_rdy", 32'(wr_ready), 32'd0);
    chk("rmid.stale_req", 32'(sdr_wr_req), 32'd0);
    init_done = 1'b1;
    tick();
    chk("rmid.rdy", 32'(wr_ready), 32'd1);
    wr_exit = 1'b1;
    tick();
    wr_exit = 1'b0;
    tick();
    chk("rmid.spur_cnt", 32'(fifo_count), 32'd0);
    chk("rmid.discarded", 32'(sdr_wr_req), 32'd0);
    push(ca[1], cd[1]);
    tick();
    chk_cmd("rmid.fresh", ca[1], cd[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
